// File: rtl/zigbee_pkg.sv
// Shared types for the zigbee transmit chain.
// Symbol/byte widths, splitter FSM states and buffer entry layout.
package zigbee_pkg;

  localparam int SYM_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              last;
    logic              full;
  } entry_t;

endpackage

// File: rtl/byte_buffer2.sv
// Two-entry byte buffer: CUR is being emitted, NXT is prefetched.
// A push in the same cycle as a pop lands in the slot free after the shift.
module byte_buffer2
  import zigbee_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_last,
  input  logic              i_pop,
  output entry_t            o_cur,
  output logic              o_nxt_full
);

  entry_t r_cur;
  entry_t r_nxt;
  entry_t w_cur;
  entry_t w_nxt;
  entry_t w_in;

  always_comb begin
    w_in  = '{data: i_byte, last: i_last, full: 1'b1};
    w_cur = i_pop ? r_nxt : r_cur;
    w_nxt = i_pop ? '0 : r_nxt;
    if (i_push) begin
      if (!w_cur.full) w_cur = w_in;
      else             w_nxt = w_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cur <= '0;
      r_nxt <= '0;
    end else begin
      r_cur <= w_cur;
      r_nxt <= w_nxt;
    end
  end

  assign o_cur      = r_cur;
  assign o_nxt_full = r_nxt.full;

endmodule

// File: rtl/symbol_splitter.sv
// Byte-to-symbol stage: emits each byte as two nibbles, low first,
// one symbol per SYM_PERIOD cycles, with the demux select alternating.
module symbol_splitter
  import zigbee_pkg::*;
#(
  parameter int SYM_PERIOD = 16
) (
  input  logic              inClk,
  input  logic              inRstN,
  input  logic [BYTE_W-1:0] inByte,
  input  logic              inValid,
  input  logic              inLast,
  output logic              outReady,
  output logic [SYM_W-1:0]  outData,
  output logic              outSel,
  output logic              outValid,
  output logic              outLast,
  output logic              outUnderrun
);

  localparam int CW = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
  localparam logic [CW-1:0] CMAX = CW'(SYM_PERIOD - 1);

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic          r_underrun;
  logic          w_underrun_nx;
  entry_t        w_cur;
  logic          w_nxt_full;
  logic          w_push;
  logic          w_pop;
  logic          w_done;

  assign outReady = !w_nxt_full;
  assign w_push   = inValid && outReady;
  assign w_done   = (r_cnt == CMAX);

  byte_buffer2 u_buf (
    .i_clk      (inClk),
    .i_rst_n    (inRstN),
    .i_push     (w_push),
    .i_byte     (inByte),
    .i_last     (inLast),
    .i_pop      (w_pop),
    .o_cur      (w_cur),
    .o_nxt_full (w_nxt_full)
  );

  always_comb begin
    w_state_nx    = r_state;
    w_pop         = 1'b0;
    w_underrun_nx = 1'b0;
    outData       = '0;
    outSel        = 1'b0;
    outLast       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cur.full) w_state_nx = LOW;
      end
      LOW: begin
        outData = w_cur.data[SYM_W-1:0];
        if (w_done) w_state_nx = HIGH;
      end
      HIGH: begin
        outData = w_cur.data[BYTE_W-1:SYM_W];
        outSel  = 1'b1;
        outLast = w_cur.last;
        if (w_done) begin
          w_pop = 1'b1;
          // A byte already in NXT or arriving now keeps the stream gapless
          if (w_nxt_full || w_push) begin
            w_state_nx = LOW;
          end else begin
            w_state_nx    = IDLE;
            w_underrun_nx = !w_cur.last;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign outValid    = (r_state != IDLE) && (r_cnt == '0);
  assign outUnderrun = r_underrun;

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_underrun <= w_underrun_nx;
      if (r_state == IDLE || w_done) r_cnt <= '0;
      else                           r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_symbol_splitter.sv
// Bench for symbol_splitter at SYM_PERIOD 4 and 1.
// Expected outputs come from a per-byte schedule of symbol start times.
module tb_symbol_splitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int P = (g == 0) ? 4 : 1;

    logic       rst_n;
    logic       vld;
    logic       lst;
    logic [7:0] byt;
    logic       rdy;
    logic [3:0] od;
    logic       sel;
    logic       ov;
    logic       ol;
    logic       ou;

    symbol_splitter #(.SYM_PERIOD(P)) dut (
      .inClk       (clk),
      .inRstN      (rst_n),
      .inByte      (byt),
      .inValid     (vld),
      .inLast      (lst),
      .outReady    (rdy),
      .outData     (od),
      .outSel      (sel),
      .outValid    (ov),
      .outLast     (ol),
      .outUnderrun (ou)
    );

    // accepted bytes: accept edge, first symbol cycle, end cycle
    int         a_q[$];
    int         s_q[$];
    int         e_q[$];
    logic [7:0] d_q[$];
    bit         l_q[$];
    // pending stimulus: byte, last flag, idle cycles before presenting
    logic [7:0] sd_q[$];
    bit         sl_q[$];
    int         sg_q[$];

    int         n;
    int         phase;
    int         rcnt;
    int         held;
    bit         took;
    bit         armed;
    bit         done;
    logic [8:0] got_v;
    logic [8:0] exp_v;

    function automatic logic [8:0] expect_at(input int c);
      logic [3:0] d = '0;
      bit v = 0, s = 0, l = 0, u = 0;
      int h = 0;
      for (int k = 0; k < a_q.size(); k++) begin
        if (a_q[k] <= c && c < e_q[k]) h++;
        if (s_q[k] <= c && c < e_q[k]) begin
          if (c - s_q[k] < P) begin
            d = d_q[k][3:0];
            v = (c == s_q[k]);
          end else begin
            d = d_q[k][7:4];
            s = 1;
            l = l_q[k];
            v = (c == s_q[k] + P);
          end
        end
        if (e_q[k] == c && !l_q[k] &&
            !(k + 1 < a_q.size() && s_q[k+1] == c)) u = 1;
      end
      return {(h < 2), v, s, l, u, d};
    endfunction

    function automatic int held_at(input int c);
      int h = 0;
      for (int k = 0; k < a_q.size(); k++)
        if (a_q[k] <= c && c < e_q[k]) h++;
      return h;
    endfunction

    function automatic bit quiet(input int c);
      for (int k = 0; k < e_q.size(); k++)
        if (e_q[k] > c - 2) return 0;
      return 1;
    endfunction

    task automatic push(input logic [7:0] b, input bit l, input int gap);
      sd_q.push_back(b);
      sl_q.push_back(l);
      sg_q.push_back(gap);
    endtask

    task automatic record(input int a, input logic [7:0] b, input bit l);
      int ep;
      int s;
      ep = (e_q.size() > 0) ? e_q[$] : -1000000;
      s  = (a <= ep) ? ep : a + 1;
      a_q.push_back(a);
      s_q.push_back(s);
      e_q.push_back(s + 2 * P);
      d_q.push_back(b);
      l_q.push_back(l);
    endtask

    task automatic load(input int ph);
      case (ph)
        0: push(8'hA5, 1, 0);
        1: begin
          push(8'h12, 0, 0);
          push(8'h34, 0, 0);
          push(8'h56, 1, 0);
        end
        2: begin
          push(8'h0F, 0, 0);
          push(8'hF0, 0, 0);
        end
        3: for (int i = 0; i < 30; i++)
             push(8'($urandom), ($urandom_range(3) == 0),
                  ($urandom_range(1) == 0) ? 0 : $urandom_range(2 * P + 2));
        4: begin
          push(8'h11, 0, 0);
          push(8'h22, 1, 0);
          armed = 1;
        end
        5: begin
          check($sformatf("P%0d rst_hit", P), 16'(armed), 16'h0);
          push(8'hC3, 1, 2);
        end
        default: ;
      endcase
    endtask

    initial begin
      rst_n = 0; vld = 0; lst = 0; byt = '0;
      n = 0; phase = -1; rcnt = 0; took = 0; armed = 0; done = 0;
      while (phase < 6 && n < 20000) begin
        @(negedge clk);
        n++;
        got_v = {rdy, ov, sel, ol, ou, od};
        exp_v = expect_at(n);
        held  = held_at(n);
        check($sformatf("P%0d c%0d", P, n), 16'(got_v), 16'(exp_v));
        if (n == 2) check($sformatf("P%0d reset", P), 16'(got_v), 16'h100);
        if (n == 3) rst_n = 1;
        if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) rst_n = 1;
        end
        if (phase == 4 && armed && held == 2 && exp_v[6]) begin
          #2 rst_n = 0;
          #1 check($sformatf("P%0d async_rst", P),
                   16'({rdy, ov, sel, ol, ou, od}), 16'h100);
          a_q.delete(); s_q.delete(); e_q.delete();
          d_q.delete(); l_q.delete();
          sd_q.delete(); sl_q.delete(); sg_q.delete();
          vld = 0; took = 0; armed = 0; rcnt = 3;
        end else begin
          if (rst_n && rcnt == 0 && sd_q.size() == 0 && !vld && !took &&
              quiet(n)) begin
            phase++;
            load(phase);
          end
          if (took) begin
            vld  = 0;
            took = 0;
          end
          if (!vld) begin
            byt = 8'($urandom);
            lst = 1'($urandom);
            if (sd_q.size() > 0 && rst_n) begin
              if (sg_q[0] > 0) sg_q[0] = sg_q[0] - 1;
              else begin
                vld = 1;
                byt = sd_q[0];
                lst = sl_q[0];
              end
            end
          end
          if (vld && rdy) begin
            record(n + 1, byt, lst);
            void'(sd_q.pop_front());
            void'(sl_q.pop_front());
            void'(sg_q.pop_front());
            took = 1;
          end
        end
      end
      check($sformatf("P%0d finished", P), 16'(phase), 16'd6);
      done = 1;
    end
  end

  initial begin
    wait (g_lane[0].done && g_lane[1].done);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
